// File: rtl/ethernet_mmio_pkg.sv
// rtl/ethernet_mmio_pkg.sv - shared MMIO address map and state type for the Ethernet TX driver
//
// Purpose : address constants for the Ethernet controller MMIO port, the
//           MMIO address width, and the TX driver state encoding.
// Ports   : none (package).
package ethernet_mmio_pkg;

  localparam int mmio_addr_width_gp = 14;

  typedef logic [mmio_addr_width_gp-1:0] mmio_addr_t;

  // TX side of the controller register/buffer window.
  localparam mmio_addr_t tx_req_addr_c  = 14'h1020;  // read, bit0=1 -> TX buffer free
  localparam mmio_addr_t tx_size_addr_c = 14'h1028;  // write byte count
  localparam mmio_addr_t tx_send_addr_c = 14'h1018;  // write any value to launch
  localparam mmio_addr_t tx_buf_addr_c  = 14'h0800;  // packet buffer base

  // RX side is reserved for a future receive driver.
  localparam mmio_addr_t rx_buf_addr_c  = 14'h0000;
  localparam mmio_addr_t rx_size_addr_c = 14'h1004;
  localparam mmio_addr_t rx_ack_addr_c  = 14'h1000;

  typedef enum logic [2:0] {
    st_idle,
    st_poll,
    st_wait_rd,
    st_gap,
    st_write_data,
    st_write_size,
    st_write_send
  } tx_state_e;

endpackage

// File: rtl/ethernet_mmio_poll_timer.sv
// rtl/ethernet_mmio_poll_timer.sv - idle-gap down-counter between TX buffer busy polls
//
// Purpose : after start_i, counts poll_gap_p cycles; expired_o is high during
//           the last of those cycles so the FSM can leave its gap state.
// Ports   : clk_i, reset_i (sync, active-high), start_i (load), expired_o.
module ethernet_mmio_poll_timer #(
  parameter int poll_gap_p = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  output logic expired_o
);

  localparam int cnt_width_lp = $clog2(poll_gap_p + 1);

  logic [cnt_width_lp-1:0] cnt_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_r <= '0;
    end else if (start_i) begin
      cnt_r <= cnt_width_lp'(poll_gap_p);
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - cnt_width_lp'(1);
    end
  end

  // A count of one marks the final gap cycle, giving exactly poll_gap_p cycles.
  assign expired_o = (cnt_r == cnt_width_lp'(1));

endmodule

// File: rtl/ethernet_mmio_tx_driver.sv
// rtl/ethernet_mmio_tx_driver.sv - MMIO initiator that pushes one packet into the Ethernet TX buffer
//
// Purpose : accepts a byte-size descriptor and a word stream, polls TX_REQ
//           until the buffer is free, writes the words into the TX buffer
//           window, writes TX_SIZE, then writes TX_SEND.
// Ports   : clk_i/reset_i (sync, active-high); pkt_size_i/_v_i/_ready_o
//           descriptor handshake; pkt_data_i/_v_i/_yumi_o word stream;
//           addr_o/write_en_o/read_en_o/op_size_o/write_data_o and
//           read_data_i/read_data_v_i MMIO master port; busy_o, done_o,
//           size_error_o status.
// Option  : ETH_MMIO_TX_DRIVER_STATS_EN adds sent_count_o and
//           poll_busy_count_o (32-bit wrapping counters).
module ethernet_mmio_tx_driver
  import ethernet_mmio_pkg::*;
#(
  parameter  int data_width_p     = 32,
  parameter  int eth_mtu_p        = 2048,
  parameter  int poll_gap_p       = 4,
  localparam int size_width_lp    = $clog2(eth_mtu_p + 1),
  localparam int bytes_lp         = data_width_p / 8,
  localparam int lg_bytes_lp      = $clog2(bytes_lp),
  localparam int op_size_width_lp = $clog2(((bytes_lp == 1) ? 1 : $clog2(bytes_lp)) + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [size_width_lp-1:0]      pkt_size_i,
  input  logic                          pkt_size_v_i,
  output logic                          pkt_size_ready_o,
  input  logic [data_width_p-1:0]       pkt_data_i,
  input  logic                          pkt_data_v_i,
  output logic                          pkt_data_yumi_o,
  output logic [mmio_addr_width_gp-1:0] addr_o,
  output logic                          write_en_o,
  output logic                          read_en_o,
  output logic [op_size_width_lp-1:0]   op_size_o,
  output logic [data_width_p-1:0]       write_data_o,
  input  logic [data_width_p-1:0]       read_data_i,
  input  logic                          read_data_v_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          size_error_o
`ifdef ETH_MMIO_TX_DRIVER_STATS_EN
  ,
  output logic [31:0]                   sent_count_o,
  output logic [31:0]                   poll_busy_count_o
`endif
);

  localparam int idx_width_lp = $clog2(eth_mtu_p / bytes_lp + 1);

  tx_state_e                state_r;
  logic [size_width_lp-1:0] size_r;
  logic [idx_width_lp-1:0]  idx_r;
  logic [idx_width_lp-1:0]  last_idx_r;

  logic                     size_bad;
  logic [size_width_lp:0]   size_round;
  logic [size_width_lp:0]   words_calc;
  logic [idx_width_lp-1:0]  last_idx_calc;
  logic                     gap_start;
  logic                     gap_expired;
  logic                     unused_read_bits;

  // Only bit0 of the TX_REQ response carries information.
  assign unused_read_bits = ^read_data_i[data_width_p-1:1];

  assign size_bad = (pkt_size_i == '0) || (pkt_size_i > size_width_lp'(eth_mtu_p));

  // ceil(size / bytes) - 1, computed one bit wider so the rounding add cannot overflow.
  assign size_round    = {1'b0, pkt_size_i} + (size_width_lp + 1)'(bytes_lp - 1);
  assign words_calc    = size_round >> lg_bytes_lp;
  assign last_idx_calc = idx_width_lp'(words_calc - (size_width_lp + 1)'(1));

  assign gap_start = (state_r == st_wait_rd) && read_data_v_i && !read_data_i[0];

  ethernet_mmio_poll_timer #(
    .poll_gap_p(poll_gap_p)
  ) poll_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (gap_start),
    .expired_o(gap_expired)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= st_idle;
      size_r       <= '0;
      idx_r        <= '0;
      last_idx_r   <= '0;
      done_o       <= 1'b0;
      size_error_o <= 1'b0;
    end else begin
      done_o       <= 1'b0;
      size_error_o <= 1'b0;
      unique case (state_r)
        st_idle: begin
          if (pkt_size_v_i) begin
            if (size_bad) begin
              size_error_o <= 1'b1;
            end else begin
              size_r     <= pkt_size_i;
              last_idx_r <= last_idx_calc;
              idx_r      <= '0;
              state_r    <= st_poll;
            end
          end
        end
        st_poll: state_r <= st_wait_rd;
        st_wait_rd: begin
          if (read_data_v_i) begin
            state_r <= read_data_i[0] ? st_write_data : st_gap;
          end
        end
        st_gap: begin
          if (gap_expired) begin
            state_r <= st_poll;
          end
        end
        st_write_data: begin
          if (pkt_data_v_i) begin
            idx_r <= idx_r + idx_width_lp'(1);
            if (idx_r == last_idx_r) begin
              state_r <= st_write_size;
            end
          end
        end
        st_write_size: state_r <= st_write_send;
        st_write_send: begin
          state_r <= st_idle;
          done_o  <= 1'b1;
        end
        default: state_r <= st_idle;
      endcase
    end
  end

  // MMIO strobes decode straight from the state register; the data phase
  // follows pkt_data_v_i so a producer bubble never generates a write.
  always_comb begin
    read_en_o       = 1'b0;
    write_en_o      = 1'b0;
    pkt_data_yumi_o = 1'b0;
    addr_o          = '0;
    write_data_o    = '0;
    unique case (state_r)
      st_poll: begin
        read_en_o = 1'b1;
        addr_o    = tx_req_addr_c;
      end
      st_write_data: begin
        if (pkt_data_v_i) begin
          write_en_o      = 1'b1;
          pkt_data_yumi_o = 1'b1;
          addr_o          = tx_buf_addr_c + (mmio_addr_t'(idx_r) << lg_bytes_lp);
          write_data_o    = pkt_data_i;
        end
      end
      st_write_size: begin
        write_en_o   = 1'b1;
        addr_o       = tx_size_addr_c;
        write_data_o = data_width_p'(size_r);
      end
      st_write_send: begin
        write_en_o   = 1'b1;
        addr_o       = tx_send_addr_c;
        write_data_o = data_width_p'(1);
      end
      default: begin
      end
    endcase
  end

  assign op_size_o        = op_size_width_lp'(lg_bytes_lp);
  assign pkt_size_ready_o = (state_r == st_idle);
  assign busy_o           = (state_r != st_idle);

`ifdef ETH_MMIO_TX_DRIVER_STATS_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sent_count_o      <= '0;
      poll_busy_count_o <= '0;
    end else begin
      if (state_r == st_write_send) begin
        sent_count_o <= sent_count_o + 32'd1;
      end
      if (gap_start) begin
        poll_busy_count_o <= poll_busy_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ethernet_mmio_tx_driver.sv
// tb/tb_ethernet_mmio_tx_driver.sv - self-checking bench for ethernet_mmio_tx_driver
module tb_ethernet_mmio_tx_driver;
  import ethernet_mmio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [11:0] pkt_size_i = '0;
  logic        pkt_size_v_i = 1'b0;
  logic        pkt_size_ready_o;
  logic [31:0] pkt_data_i = '0;
  logic        pkt_data_v_i = 1'b0;
  logic        pkt_data_yumi_o;
  logic [13:0] addr_o;
  logic        write_en_o;
  logic        read_en_o;
  logic [1:0]  op_size_o;
  logic [31:0] write_data_o;
  logic [31:0] read_data_i = '0;
  logic        read_data_v_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        size_error_o;
`ifdef ETH_MMIO_TX_DRIVER_STATS_EN
  logic [31:0] sent_count;
  logic [31:0] poll_busy_count;
`endif

  always #5 clk = ~clk;

  ethernet_mmio_tx_driver dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .pkt_size_i      (pkt_size_i),
    .pkt_size_v_i    (pkt_size_v_i),
    .pkt_size_ready_o(pkt_size_ready_o),
    .pkt_data_i      (pkt_data_i),
    .pkt_data_v_i    (pkt_data_v_i),
    .pkt_data_yumi_o (pkt_data_yumi_o),
    .addr_o          (addr_o),
    .write_en_o      (write_en_o),
    .read_en_o       (read_en_o),
    .op_size_o       (op_size_o),
    .write_data_o    (write_data_o),
    .read_data_i     (read_data_i),
    .read_data_v_i   (read_data_v_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
`ifdef ETH_MMIO_TX_DRIVER_STATS_EN
    .sent_count_o     (sent_count),
    .poll_busy_count_o(poll_busy_count),
`endif
    .size_error_o    (size_error_o)
  );

  typedef struct packed {
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int writes = 0;
  int reads = 0;
  int dones = 0;
  int serrs = 0;
  int yumis = 0;
  int done_cyc = 0;
  int last_rd = -1;
  int busy_left = 0;
  bit rd_pend = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [13:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc++;

  // Controller side: answer each read one cycle later, busy for busy_left polls.
  always @(posedge clk) begin
    #1;
    if (rd_pend) begin
      read_data_v_i = 1'b1;
      read_data_i   = (busy_left > 0) ? 32'd0 : 32'd1;
      if (busy_left > 0) busy_left--;
      rd_pend = 1'b0;
    end else begin
      read_data_v_i = 1'b0;
      read_data_i   = 32'd0;
    end
  end

  // Bus monitor and scoreboard consumer.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (write_en_o) begin
        writes++;
        chk("strobe_excl", {63'd0, read_en_o}, 64'd0);
        chk("op_size", {62'd0, op_size_o}, 64'd2);
        chk("wr_expected", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", {50'd0, addr_o}, {50'd0, mon_e.addr});
          chk("wr_data", {32'd0, write_data_o}, {32'd0, mon_e.data});
        end
      end
      if (read_en_o) begin
        reads++;
        chk("rd_addr", {50'd0, addr_o}, {50'd0, tx_req_addr_c});
        if (last_rd >= 0) chk("poll_gap", {63'd0, (cyc - last_rd - 1) >= 4}, 64'd1);
        last_rd = cyc;
        rd_pend = 1'b1;
      end
      if (done_o) begin
        dones++;
        done_cyc = cyc;
      end
      if (size_error_o) serrs++;
      if (pkt_data_yumi_o) yumis++;
    end
  end

  task automatic send_pkt(input int size, input bit bubble, input int busy_polls, input int exp_lat);
    int n, w0, r0, d0, y0, acc, i, guard;
    bit took;
    logic [31:0] words[$];
    n = (size + 3) / 4;
    for (int k = 0; k < n; k++) begin
      words.push_back($urandom);
      push_wr(tx_buf_addr_c + 14'(4 * k), words[k]);
    end
    push_wr(tx_size_addr_c, 32'(size));
    push_wr(tx_send_addr_c, 32'd1);
    @(posedge clk); #1;
    busy_left = busy_polls;
    last_rd = -1;
    w0 = writes; r0 = reads; d0 = dones; y0 = yumis;
    pkt_size_i = 12'(size);
    pkt_size_v_i = 1'b1;
    @(negedge clk);
    chk("desc_ready", {63'd0, pkt_size_ready_o}, 64'd1);
    acc = cyc;
    @(posedge clk); #1;
    pkt_size_v_i = 1'b0;
    i = 0;
    guard = 0;
    while (i < n && guard < 2000) begin
      pkt_data_v_i = 1'b1;
      pkt_data_i = words[i];
      @(negedge clk);
      guard++;
      took = pkt_data_yumi_o;
      if (took) i++;
      @(posedge clk); #1;
      if (took && bubble) begin
        pkt_data_v_i = 1'b0;
        @(posedge clk); #1;
      end
    end
    pkt_data_v_i = 1'b0;
    guard = 0;
    while (dones == d0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("words_sent", 64'(i), 64'(n));
    chk("yumi_count", 64'(yumis - y0), 64'(n));
    chk("done_count", 64'(dones - d0), 64'd1);
    chk("write_count", 64'(writes - w0), 64'(n + 2));
    chk("read_count", 64'(reads - r0), 64'(busy_polls + 1));
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    if (exp_lat >= 0) chk("latency", 64'(done_cyc - (acc + 1)), 64'(exp_lat));
  endtask

  task automatic bad_desc(input int size);
    int w0, r0, y0, s0;
    @(posedge clk); #1;
    w0 = writes; r0 = reads; y0 = yumis; s0 = serrs;
    pkt_data_v_i = 1'b1;
    pkt_data_i = $urandom;
    pkt_size_i = 12'(size);
    pkt_size_v_i = 1'b1;
    @(negedge clk);
    chk("bad_ready", {63'd0, pkt_size_ready_o}, 64'd1);
    @(posedge clk); #1;
    pkt_size_v_i = 1'b0;
    @(negedge clk);
    chk("size_err_pulse", {63'd0, size_error_o}, 64'd1);
    chk("size_err_idle", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    chk("size_err_clear", {63'd0, size_error_o}, 64'd0);
    repeat (4) @(negedge clk);
    chk("bad_no_writes", 64'(writes - w0), 64'd0);
    chk("bad_no_reads", 64'(reads - r0), 64'd0);
    chk("bad_no_yumi", 64'(yumis - y0), 64'd0);
    chk("bad_err_count", 64'(serrs - s0), 64'd1);
    @(posedge clk); #1;
    pkt_data_v_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int i, guard, w0, y0;
    bit took;
    logic [31:0] words[$];

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {63'd0, pkt_size_ready_o}, 64'd1);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_size_err", {63'd0, size_error_o}, 64'd0);
    chk("rst_strobes", {62'd0, write_en_o, read_en_o}, 64'd0);
    chk("rst_yumi", {63'd0, pkt_data_yumi_o}, 64'd0);
    @(posedge clk); #1;
    reset_i = 1'b0;

    send_pkt(64, 1'b0, 0, 20);
    send_pkt(61, 1'b0, 0, 20);
    bad_desc(0);
    bad_desc(2049);
    send_pkt(32, 1'b0, 3, -1);
    send_pkt(32, 1'b1, 0, -1);

    // Reset in the middle of a 16-word packet, after 5 words.
    @(posedge clk); #1;
    busy_left = 0;
    last_rd = -1;
    w0 = writes; y0 = yumis;
    for (int k = 0; k < 16; k++) words.push_back($urandom);
    for (int k = 0; k < 5; k++) push_wr(tx_buf_addr_c + 14'(4 * k), words[k]);
    pkt_size_i = 12'd64;
    pkt_size_v_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    pkt_size_v_i = 1'b0;
    i = 0;
    guard = 0;
    while (i < 5 && guard < 200) begin
      pkt_data_v_i = 1'b1;
      pkt_data_i = words[i];
      @(negedge clk);
      guard++;
      took = pkt_data_yumi_o;
      if (took) i++;
      @(posedge clk); #1;
    end
    pkt_data_v_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    pkt_data_v_i = 1'b1;
    pkt_data_i = words[5];
    @(negedge clk);
    chk("rstmid_strobes", {62'd0, write_en_o, read_en_o}, 64'd0);
    chk("rstmid_busy", {63'd0, busy_o}, 64'd0);
    chk("rstmid_ready", {63'd0, pkt_size_ready_o}, 64'd1);
    repeat (5) @(negedge clk);
    chk("rstmid_writes", 64'(writes - w0), 64'd5);
    chk("rstmid_yumis", 64'(yumis - y0), 64'd5);
    chk("rstmid_sb", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    pkt_data_v_i = 1'b0;

    send_pkt(8, 1'b0, 0, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ethernet_mmio_tx_driver.md
Name: ethernet_mmio_tx_driver

Overview:
- MMIO initiator that drives the Ethernet controller's register/buffer port from the host side: accepts a packet descriptor (byte size) plus a word stream, polls TX-buffer availability, writes packet words into the TX buffer window, writes the size register, then triggers send.
- Sits between an on-chip producer (test harness, DMA, or NIC offload) and the controller's MMIO slave port. It is the opposite end of that port.

Parameters:
- data_width_p, 32, MMIO data width in bits (32 or 64).
- eth_mtu_p, 2048, maximum packet size in bytes.
- poll_gap_p, 4, idle cycles between consecutive busy polls (>=1).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- pkt_size_i  in  $clog2(eth_mtu_p+1)  packet size in bytes
- pkt_size_v_i  in  1  descriptor valid
- pkt_size_ready_o  out  1  descriptor accepted when v&ready
- pkt_data_i  in  data_width_p  packet word, little-endian byte order
- pkt_data_v_i  in  1  word valid
- pkt_data_yumi_o  out  1  word consumed this cycle
- addr_o  out  14  MMIO address
- write_en_o  out  1  MMIO write strobe (one cycle per write, always accepted)
- read_en_o  out  1  MMIO read strobe (one cycle per read)
- op_size_o  out  `BSG_WIDTH(`BSG_SAFE_CLOG2(data_width_p/8))  log2 access bytes
- write_data_o  out  data_width_p  MMIO write data
- read_data_i  in  data_width_p  MMIO read data
- read_data_v_i  in  1  read data valid (sync read, >=1 cycle after read_en_o)
- busy_o  out  1  not in IDLE
- done_o  out  1  one-cycle pulse after send trigger written
- size_error_o  out  1  one-cycle pulse on illegal descriptor

Behaviour:
- Address map (package constants):
  - TX_REQ 14'h1020: read; bit0=1 means the TX buffer is free.
  - TX_SIZE 14'h1028: write byte count.
  - TX_SEND 14'h1018: write any value to trigger send.
  - TX_BUF 14'h0800 base: word i goes to TX_BUF + i*(data_width_p/8).
- Reset: FSM to IDLE; all outputs 0 except pkt_size_ready_o=1. Counters cleared.
- States:
  - IDLE:
    - pkt_size_ready_o=1.
    - On handshake: size==0 or size>eth_mtu_p -> size_error_o pulse next cycle, stay IDLE, consume no data.
    - Otherwise latch size, compute words=ceil(size/(data_width_p/8)), go POLL.
  - POLL: read_en_o=1, addr_o=TX_REQ, one cycle -> WAIT_RD.
  - WAIT_RD:
    - Hold until read_data_v_i.
    - bit0=1 -> WRITE_DATA.
    - bit0=0 -> GAP (poll_gap_p cycles) -> POLL.
    - A read_data_v_i arriving in the same cycle as the state is entered is valid.
  - WRITE_DATA:
    - When pkt_data_v_i: write_en_o=1, addr_o=TX_BUF+idx*bytes, write_data_o=pkt_data_i, yumi=1, idx++.
    - No strobe while v=0 (bubble allowed).
    - After word words-1 -> WRITE_SIZE.
  - WRITE_SIZE: write_en_o=1, addr_o=TX_SIZE, write_data_o=zero-extended size -> WRITE_SEND.
  - WRITE_SEND: write_en_o=1, addr_o=TX_SEND, data=1 -> IDLE with done_o=1 next cycle.
- Access width: op_size_o = log2(data_width_p/8) for every access. The final partial word is written full-width; bytes beyond size are don't-care.
- Index counter width: $clog2(eth_mtu_p/(data_width_p/8)+1). No wrap occurs because size is bounded.
- Strobes are mutually exclusive and never asserted in IDLE/WAIT_RD/GAP.
- read_data_v_i outside WAIT_RD is ignored.
- Reset mid-packet: partial buffer contents are abandoned, no size/send write is issued, remaining producer words are left unconsumed.
- Latency, best case (buffer free, data ready): POLL + 1-cycle read + N data + 2 = N+4 cycles from accept to done_o.

Optional Feature:
- ETH_MMIO_TX_DRIVER_STATS_EN:
  - Defined: adds outputs sent_count_o[31:0], incremented on each done_o, and poll_busy_count_o[31:0], incremented on each bit0=0 response. Both wrap at 2^32 and clear on reset.
  - Undefined: ports and counters are absent.

Decomposition:
- Package ethernet_mmio_pkg: address constants (TX_REQ, TX_SIZE, TX_SEND, TX_BUF, RX_* reserved), the state enum typedef, and the MMIO address width (14).
- Sub-module: ethernet_mmio_poll_timer, a poll_gap_p down-counter with start/expired handshake. The FSM stays in the top module.

Test Plan:
- Free buffer, size=64, 16 words streamed back-to-back -> 1 read, 16 writes at 0x0800..0x083C, write 0x1028=64, write 0x1018, done_o at cycle 20 after accept.
- size=61 -> 16 data writes, TX_SIZE written 61.
- size=0 and size=2049 -> size_error_o pulse, no MMIO strobes, pkt_data_yumi_o stays 0.
- TX_REQ returns 0 three times then 1, poll_gap_p=4 -> 4 reads each separated by >=4 idle cycles, then data writes.
- pkt_data_v_i toggling 1/0 during 8-word packet -> exactly 8 writes with contiguous addresses, no write on bubbles.
- reset_i asserted after 5 of 16 words -> next cycle all strobes 0, busy_o=0, no size/send write. A fresh size=8 packet then completes normally.
